// File: rtl/alu_32.sv
// Purpose: 32-bit execute-stage ALU, eight logic/arithmetic ops with NZCV flags, plus a registered copy.
// Latency: result/flags are combinational (0 cycles); result_q/flags_q follow one clk later.
// Backpressure: none; a new operation is accepted every cycle.
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q
);

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             arith_v;
    flags_t           flags;

    // Subtraction reuses the adder as a + ~b + 1, so carry set means "no borrow".
    assign is_sub   = (op == OP_SUB);
    assign is_arith = (op == OP_ADD) || is_sub;
    assign b_eff    = is_sub ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    // Operands (after inversion for sub) agree in sign but the result does not.
    assign arith_v  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result = '0;
        unique case (op)
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = sum[WIDTH-1:0];
            default: result = '0;
        endcase
    end

    always_comb begin
        flags   = '0;
        flags.n = result[WIDTH-1];
        flags.z = (result == '0);
        flags.c = is_arith & sum[WIDTH];
        flags.v = is_arith & arith_v;
    end

    assign n = flags.n;
    assign z = flags.z;
    assign c = flags.c;
    assign v = flags.v;

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result;
            flags_q  <= flags;
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Directed-vector bench for alu_32: combinational result/NZCV and the registered copies.
module tb_alu_32;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] result;
    logic        c, n, z, v;
    logic [31:0] result_q;
    logic [3:0]  flags_q;

    int tests_run = 0;
    int tests_failed = 0;

    alu_32 dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .c        (c),
        .n        (n),
        .z        (z),
        .v        (v),
        .result_q (result_q),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[$];

    // Inputs change 1 ns after a posedge; comb outputs sampled 4 ns later,
    // registered outputs 1 ns after the following posedge.
    task automatic apply(input vec_t t);
        op = t.op;
        a  = t.a;
        b  = t.b;
        #4;
        check({t.name, " result"}, result, t.r);
        check({t.name, " nzcv"}, {28'h0, n, z, c, v}, {28'h0, t.nzcv});
        @(posedge clk);
        #1;
        if (reset) begin
            check({t.name, " result_q"}, result_q, t.r);
            check({t.name, " flags_q"}, {28'h0, flags_q}, {28'h0, t.nzcv});
        end else begin
            check({t.name, " result_q rst"}, result_q, 32'h0);
            check({t.name, " flags_q rst"}, {28'h0, flags_q}, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b0;
        op    = 3'b000;
        a     = 32'h0;
        b     = 32'h0;

        vecs.push_back('{"add_ovf",    3'b110, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001});
        vecs.push_back('{"add_wrap",   3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110});
        vecs.push_back('{"sub_ovf",    3'b111, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011});
        vecs.push_back('{"sub_borrow", 3'b111, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"sub_eq",     3'b111, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110});
        vecs.push_back('{"and_zero",   3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100});
        vecs.push_back('{"nota_zero",  3'b000, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"xnor_eq",    3'b101, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"notb",       3'b001, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 4'b1000});
        vecs.push_back('{"or",         3'b011, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000});
        vecs.push_back('{"xor",        3'b100, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"and_ones",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"add_small",  3'b110, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000});
        vecs.push_back('{"add_negovf", 3'b110, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111});
        vecs.push_back('{"sub_neg",    3'b111, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000});
        vecs.push_back('{"sub_posovf", 3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1001});
        vecs.push_back('{"sub_zero",   3'b111, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0110});

        // Reset held: combinational path live, registers forced to zero.
        @(posedge clk);
        #1;
        apply(vecs[0]);

        reset = 1'b1;
        foreach (vecs[i]) apply(vecs[i]);

        // Reset is synchronous: registers keep the last value until the edge.
        reset = 1'b0;
        op = 3'b011;
        a  = 32'h0000F000;
        b  = 32'h0000000F;
        #4;
        check("rst_sync result_q", result_q, 32'h00000000);
        check("rst_sync flags_q", {28'h0, flags_q}, {28'h0, 4'b0110});
        check("rst_comb result", result, 32'h0000F00F);
        @(posedge clk);
        #1;
        check("rst_edge result_q", result_q, 32'h0);
        check("rst_edge flags_q", {28'h0, flags_q}, 32'h0);

        reset = 1'b1;
        apply(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
